// File: rtl/uart_io_ctrl_if.sv
// uart_io_ctrl_if: CPU memory-stage data port plus UART RX/TX ready/valid channels.
//   slave  : the I/O controller side (decodes CPU accesses, drives UART handshakes)
//   master : the CPU + UART side that drives the controller
interface uart_io_ctrl_if;
    // CPU data port
    logic        stall;
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic        sel;
    logic [31:0] rdata;
    // UART receive channel
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    // UART transmit channel
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;

    modport slave (
        input  stall, addr, re, we, wdata,
        output sel, rdata,
        input  uart_rx_data, uart_rx_valid,
        output uart_rx_ready,
        output uart_tx_data, uart_tx_valid,
        input  uart_tx_ready
    );

    modport master (
        output stall, addr, re, we, wdata,
        input  sel, rdata,
        output uart_rx_data, uart_rx_valid,
        input  uart_rx_ready,
        input  uart_tx_data, uart_tx_valid,
        output uart_tx_ready
    );
endinterface

// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl: memory-mapped UART controller for the MIPS150 memory stage.
// Decodes a 32-byte I/O window, buffers received bytes in an RX FIFO, holds one
// outgoing TX byte and runs a free-running 32-bit cycle counter.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - uart_io_ctrl_if.slave (CPU data port + UART RX/TX handshakes)
module uart_io_ctrl #(
    parameter int unsigned RX_DEPTH  = 4,
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    uart_io_ctrl_if.slave   bus
);
    localparam int unsigned AW = $clog2(RX_DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [2:0] OFF_RX_STAT = 3'd0;
    localparam logic [2:0] OFF_RX_DATA = 3'd1;
    localparam logic [2:0] OFF_TX_STAT = 3'd2;
    localparam logic [2:0] OFF_TX_DATA = 3'd3;
    localparam logic [2:0] OFF_CYCLE   = 3'd4;

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [7:0]    r_mem [RX_DEPTH];
    logic          r_tx_full;
    logic [7:0]    r_tx_data;
    logic [31:0]   r_cycle_cnt;
    logic [31:0]   r_rdata;

    logic          w_sel;
    logic [2:0]    w_off;
    logic          w_rd;
    logic          w_wr;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_tx_xfer;
    logic          w_tx_load;
    logic          w_cnt_clr;
    logic [31:0]   w_rd_mux;
    logic          w_unused_bits;

    // Address decode; a write wins over a simultaneous read
    assign w_sel = (bus.addr[31:5] == ADDR_BASE[31:5]);
    assign w_off = bus.addr[4:2];
    assign w_rd  = w_sel & ~bus.stall & bus.re & ~bus.we;
    assign w_wr  = w_sel & ~bus.stall & bus.we;

    // FIFO flags from extra pointer MSB
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = bus.uart_rx_valid & bus.uart_rx_ready;
    assign w_pop   = w_rd & (w_off == OFF_RX_DATA) & ~w_empty;

    // TX load uses registered tx_full, so a write racing a transfer is dropped
    assign w_tx_xfer = r_tx_full & bus.uart_tx_ready;
    assign w_tx_load = w_wr & (w_off == OFF_TX_DATA) & ~r_tx_full;
    assign w_cnt_clr = w_wr & (w_off == OFF_CYCLE);

    assign w_unused_bits = ^{bus.addr[1:0], bus.wdata[31:8]};

    // Read data mux
    always_comb begin
        w_rd_mux = 32'd0;
        case (w_off)
            OFF_RX_STAT: w_rd_mux = {31'd0, ~w_empty};
            OFF_RX_DATA: w_rd_mux = w_empty ? 32'd0 : {24'd0, r_mem[r_rptr[AW-1:0]]};
            OFF_TX_STAT: w_rd_mux = {31'd0, ~r_tx_full};
            OFF_CYCLE:   w_rd_mux = r_cycle_cnt;
            default:     w_rd_mux = 32'd0;
        endcase
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    // FIFO storage, contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= bus.uart_rx_data;
    end

    // TX holding buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_full <= 1'b0;
            r_tx_data <= 8'd0;
        end else if (w_tx_xfer) begin
            r_tx_full <= 1'b0;
        end else if (w_tx_load) begin
            r_tx_full <= 1'b1;
            r_tx_data <= bus.wdata[7:0];
        end
    end

    // Free-running cycle counter, CPU clear has priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_cycle_cnt <= 32'd0;
        else if (w_cnt_clr) r_cycle_cnt <= 32'd0;
        else                r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end

    // Load data: held across stall, zero after any non-read cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            r_rdata <= 32'd0;
        else if (!bus.stall) r_rdata <= w_rd ? w_rd_mux : 32'd0;
    end

    assign bus.sel           = w_sel;
    assign bus.rdata         = r_rdata;
    assign bus.uart_rx_ready = rst & ~w_full;
    assign bus.uart_tx_valid = r_tx_full;
    assign bus.uart_tx_data  = r_tx_data;
endmodule
